// File: rtl/imem_if.sv
// imem_if: fetch and program-load port bundle for imem_loadable
interface imem_if #(parameter int N = 32, parameter int ADDR_W = 7);
  logic [ADDR_W-1:0] addr;
  logic              stall;
  logic [N-1:0]      q;
  logic              q_valid;
  logic              busy;
  logic              load_start;
  logic              wr_valid;
  logic [N-1:0]      wr_data;
  logic              wr_last;
  logic              wr_ready;
  logic [ADDR_W:0]   load_count;
  modport master (output addr, stall, load_start, wr_valid, wr_data, wr_last,
                  input q, q_valid, busy, wr_ready, load_count);
  modport slave (input addr, stall, load_start, wr_valid, wr_data, wr_last,
                 output q, q_valid, busy, wr_ready, load_count);
endinterface

// File: rtl/imem_loadable.sv
// imem_loadable: NOP-cleared instruction memory with registered fetch and run-time program load
module imem_loadable #(
  parameter int          N      = 32,
  parameter int          ADDR_W = 7,
  parameter logic [N-1:0] NOP   = 32'h8b1f03ff
) (
  input logic   clk,
  input logic   reset,
  imem_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic [1:0] {CLEAR, RUN, LOAD} state_t;
  state_t            state, next;
  logic [N-1:0]      mem [DEPTH];
  logic [ADDR_W-1:0] clr_cnt, wr_ptr, wa;
  logic [N-1:0]      wd;
  logic              we, done;
  always_ff @(posedge clk) state <= reset ? CLEAR : next;
  always_comb begin
    done = bus.wr_valid && (bus.wr_last || wr_ptr == '1);
    next = state == CLEAR ? (clr_cnt == '1 ? RUN : CLEAR) :
           state == RUN   ? (bus.load_start ? LOAD : RUN) :
                            (done ? RUN : LOAD);
    we = state == CLEAR || (state == LOAD && bus.wr_valid);
    wa = state == CLEAR ? clr_cnt : wr_ptr;
    wd = state == CLEAR ? NOP : bus.wr_data;
    bus.busy = state != RUN;
    bus.wr_ready = state == LOAD;
  end
  always_ff @(posedge clk) if (we) mem[wa] <= wd;
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_cnt        <= '0;
      wr_ptr         <= '0;
      bus.q          <= NOP;
      bus.q_valid    <= 1'b0;
      bus.load_count <= '0;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
    end else if (state == RUN) begin
      // a load request takes priority over the fetch in the same cycle
      if (bus.load_start) begin
        wr_ptr         <= '0;
        bus.load_count <= '0;
        bus.q          <= NOP;
        bus.q_valid    <= 1'b0;
      end else if (!bus.stall) begin
        bus.q       <= mem[bus.addr];
        bus.q_valid <= 1'b1;
      end
    end else if (bus.wr_valid) begin
      wr_ptr         <= wr_ptr + 1'b1;
      bus.load_count <= bus.load_count + 1'b1;
    end
  end
endmodule
